seg_execute_md: RTL and testbench
=================================

Name: seg_execute_md

Overview:
Next-generation MIPS execute stage with operand forwarding, a registered EX/MEM output latch, and an iterative multiply/divide unit with HI/LO registers.
- Sits between the ID/EX latch and the memory stage.
- ALU operations complete in one cycle.
- MULT/MULTU/DIV/DIVU run in the background over NB_DATA cycles.
- Raises o_stall to the hazard unit only when a dependent HI/LO instruction arrives early.

Parameters:
NB_ADDR, 32, PC width
NB_DATA, 32, datapath width (even, ≥8)
NB_REG, 5, register index width
NB_ALUCTL, 4, decoded ALU control width
NB_MDOP, 4, mul/div opcode width
NB_CTRL_WBM, 5, WB+M control bits passed through

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_valid  in  1  ID/EX holds a live instruction
i_flush  in  1  squash instruction in EX
i_PC  in  NB_ADDR  PC+4 of instruction
i_read_data_1  in  NB_DATA  rs value from register file
i_read_data_2  in  NB_DATA  rt value from register file
i_imm  in  NB_DATA  sign-extended immediate
i_rt  in  NB_REG  rt index
i_rd  in  NB_REG  rd index
i_reg_dst  in  1  1=rd, 0=rt
i_alu_src  in  1  1=immediate operand B
i_alu_ctl  in  NB_ALUCTL  ALU operation
i_md_op  in  NB_MDOP  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
i_fwd_a  in  2  0 reg, 1 EX/MEM, 2 MEM/WB
i_fwd_b  in  2  0 reg, 1 EX/MEM, 2 MEM/WB
i_exmem_result  in  NB_DATA  forwarded EX/MEM value
i_memwb_result  in  NB_DATA  forwarded MEM/WB value
i_ctrl_wbm  in  NB_CTRL_WBM  WB+M control bits
o_branch_pc  out  NB_ADDR  registered i_PC + (i_imm<<2)
o_result  out  NB_DATA  registered ALU / HI / LO result
o_zero  out  1  registered ALU-zero flag
o_store_data  out  NB_DATA  registered forwarded B (before immediate mux)
o_write_reg  out  NB_REG  registered destination index
o_ctrl_wbm  out  NB_CTRL_WBM  registered control; 0 = bubble
o_stall  out  1  combinational; hold ID/EX and earlier stages
o_md_busy  out  1  mul/div FSM in BUSY

Behaviour:
- Reset: i_rst is synchronous, active-low; clock is i_clk. On reset, all registered outputs, HI, LO, counter and partial registers go to 0, and the FSM goes to IDLE. Reset mid-operation aborts it and leaves HI/LO = 0.
- Operand A = mux(i_fwd_a); forwarded B = mux(i_fwd_b); fwd code 3 behaves as 0.
- ALU operand B = i_alu_src ? i_imm : forwarded B.
- ALU is combinational (seg_execute_alu). Latency is 1 clock to the EX/MEM outputs.
- o_result:
  - HI for MFHI, LO for MFLO.
  - ALU output otherwise.
  - o_zero always reflects the ALU output.
- MTHI/MTLO write operand A into HI/LO at the clock edge.
- Mul/div FSM, IDLE → BUSY → IDLE:
  - Accept when state==IDLE, i_valid, op ∈ {1..4} and no flush: latch operand magnitudes and sign info, load counter = NB_DATA-1.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle.
  - When counter==0, the same edge writes HI/LO and returns to IDLE. BUSY therefore lasts exactly NB_DATA cycles.
- Signed ops:
  - MULT: negate the 2·NB_DATA product if operand signs differ.
  - DIV: quotient sign = XOR of signs; remainder takes the dividend's sign.
- Results:
  - Multiply: HI = upper half, LO = lower half.
  - Divide: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend; completes in the normal NB_DATA cycles.
- DIV overflow (min/-1): LO = min, HI = 0.
- o_stall = o_md_busy & i_valid & (i_md_op ∈ {1..8}). Non-mul/div instructions flow during BUSY.
- While stalled:
  - EX/MEM captures a bubble (o_ctrl_wbm = 0).
  - HI/LO and FSM are unaffected by the stalled op.
  - No new op is accepted.
- i_flush or !i_valid: o_ctrl_wbm = 0 next cycle, no mul/div accepted, no MTHI/MTLO write. A flush does not abort an already-BUSY operation.
- Simultaneous completion and a new MTHI/MTLO cannot occur, because MT* stalls while BUSY.

Decomposition:
- Package mips_ex_pkg holds:
  - MD opcode constants and forward-select constants.
  - NB_* width defaults.
  - ALU control codes shared with seg_execute_alu_control.
- Sub-module seg_execute_muldiv: FSM, counter, partial product/remainder, HI/LO, busy.
- seg_execute_alu is reused unchanged.

Test Plan:
- ADD, fwd_a=1 (exmem=5), reg B=7 → next-cycle o_result=12, o_zero=0, o_write_reg=rd when reg_dst=1.
- MULT -3 × 7 → o_md_busy for 32 cycles. MFLO issued in busy cycle 5 stalls until done, then returns 0xFFFFFFEB; MFHI returns 0xFFFFFFFF.
- DIVU 100/7 with independent ADDs during BUSY → ADDs never stall; afterwards LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 9/0 → LO=0xFFFFFFFF, HI=9.
- i_flush with MULT in EX → no busy, HI/LO unchanged, o_ctrl_wbm=0.
- i_rst low at busy cycle 10 → next cycle busy=0, HI=LO=0, all outputs 0.

Source files
------------

// File: rtl/mips_ex_pkg.sv
// Shared definitions for the MIPS execute stage.
// Holds the default widths, the mul/div opcode encoding, the forwarding-select
// codes, the ALU control codes and the mul/div FSM state type.
package mips_ex_pkg;

  localparam int NB_ADDR_DEF     = 32;
  localparam int NB_DATA_DEF     = 32;
  localparam int NB_REG_DEF      = 5;
  localparam int NB_ALUCTL_DEF   = 4;
  localparam int NB_MDOP_DEF     = 4;
  localparam int NB_CTRL_WBM_DEF = 5;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  // Opcodes that launch a background multiply/divide.
  function automatic logic md_is_start(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  // Opcodes that touch HI/LO and must wait for a running operation.
  function automatic logic md_is_any(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

endpackage

// File: rtl/seg_execute_alu.sv
// Combinational ALU of the execute stage.
// Ports: a_i/b_i operands, ctl_i operation code, result_o result,
// zero_o high when result_o is zero.
module seg_execute_alu
  import mips_ex_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_ALUCTL = NB_ALUCTL_DEF
) (
  input  logic [NB_DATA-1:0]   a_i,
  input  logic [NB_DATA-1:0]   b_i,
  input  logic [NB_ALUCTL-1:0] ctl_i,
  output logic [NB_DATA-1:0]   result_o,
  output logic                 zero_o
);

  logic signed [NB_DATA-1:0] a_s;
  logic signed [NB_DATA-1:0] b_s;

  assign a_s = a_i;
  assign b_s = b_i;

  always_comb begin
    result_o = '0;
    case (ctl_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD:  result_o = a_i + b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLT:  result_o = {{(NB_DATA-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result_o = {{(NB_DATA-1){1'b0}}, (a_i < b_i)};
      ALU_NOR:  result_o = ~(a_i | b_i);
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/seg_execute_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers.
// Ports: i_clk/i_rst (sync, active-low), start_i launches op_i on a_i/b_i,
// mthi_i/mtlo_i write a_i into HI/LO, hi_o/lo_o current HI/LO, busy_o FSM busy.
// Works on operand magnitudes (one shift-add or restoring-subtract step per
// cycle, NB_DATA cycles) and applies the sign correction on the final edge.
module seg_execute_muldiv
  import mips_ex_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_MDOP = NB_MDOP_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               start_i,
  input  logic [NB_MDOP-1:0] op_i,
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  input  logic               mthi_i,
  input  logic               mtlo_i,
  output logic [NB_DATA-1:0] hi_o,
  output logic [NB_DATA-1:0] lo_o,
  output logic               busy_o
);

  localparam int NB_CNT = $clog2(NB_DATA);

  md_state_e           state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0]  acc_q, acc_d;    // upper product half / partial remainder
  logic [NB_DATA-1:0]  part_q, part_d;  // multiplier / dividend, shifted out
  logic [NB_DATA-1:0]  opb_q, opb_d;    // multiplicand / divisor magnitude
  logic [NB_DATA-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;        // negate product / quotient
  logic                neg_rem_q, neg_rem_d; // remainder follows dividend sign
  logic                dz_q, dz_d;          // divide by zero

  logic                signed_op, a_neg, b_neg;
  logic [NB_DATA-1:0]  a_mag, b_mag;
  logic [NB_DATA:0]    mul_sum, div_shift, div_diff;
  logic                div_ge;
  logic [NB_DATA-1:0]  acc_step, part_step, quot_fix, rem_fix;
  logic [2*NB_DATA-1:0] prod, prod_fix;

  assign signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign a_neg     = signed_op & a_i[NB_DATA-1];
  assign b_neg     = signed_op & b_i[NB_DATA-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;

  assign mul_sum   = {1'b0, acc_q} + (part_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {acc_q, part_q[NB_DATA-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_diff  = div_shift - {1'b0, opb_q};

  assign acc_step  = is_div_q ? (div_ge ? div_diff[NB_DATA-1:0] : div_shift[NB_DATA-1:0])
                              : mul_sum[NB_DATA:1];
  assign part_step = is_div_q ? {part_q[NB_DATA-2:0], div_ge}
                              : {mul_sum[0], part_q[NB_DATA-1:1]};

  assign prod      = {acc_step, part_step};
  assign prod_fix  = neg_q ? -prod : prod;
  assign quot_fix  = neg_q ? -part_step : part_step;
  assign rem_fix   = neg_rem_q ? -acc_step : acc_step;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    part_d    = part_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d   = MD_BUSY;
          cnt_d     = NB_CNT'(NB_DATA - 1);
          acc_d     = '0;
          part_d    = a_mag;
          opb_d     = b_mag;
          is_div_d  = (op_i == MD_DIV) || (op_i == MD_DIVU);
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (b_i == '0);
        end else begin
          if (mthi_i) hi_d = a_i;
          if (mtlo_i) lo_d = a_i;
        end
      end
      MD_BUSY: begin
        acc_d  = acc_step;
        part_d = part_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          if (is_div_q) begin
            // With a zero divisor the remainder path already holds the
            // dividend; only the quotient needs forcing to all ones.
            lo_d = dz_q ? '1 : quot_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*NB_DATA-1:NB_DATA];
            lo_d = prod_fix[NB_DATA-1:0];
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      part_q    <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      part_q    <= part_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/seg_execute_md.sv
// MIPS execute stage: operand forwarding, ALU, background mul/div with HI/LO,
// and the EX/MEM output latch.
// Inputs: ID/EX fields (i_valid, i_flush, i_PC, operands, indices, controls,
// i_md_op), forwarding selects and forwarded values, i_ctrl_wbm.
// Outputs: registered EX/MEM fields (o_branch_pc, o_result, o_zero,
// o_store_data, o_write_reg, o_ctrl_wbm), combinational o_stall, o_md_busy.
module seg_execute_md
  import mips_ex_pkg::*;
#(
  parameter int NB_ADDR     = NB_ADDR_DEF,
  parameter int NB_DATA     = NB_DATA_DEF,
  parameter int NB_REG      = NB_REG_DEF,
  parameter int NB_ALUCTL   = NB_ALUCTL_DEF,
  parameter int NB_MDOP     = NB_MDOP_DEF,
  parameter int NB_CTRL_WBM = NB_CTRL_WBM_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic                   i_flush,
  input  logic [NB_ADDR-1:0]     i_PC,
  input  logic [NB_DATA-1:0]     i_read_data_1,
  input  logic [NB_DATA-1:0]     i_read_data_2,
  input  logic [NB_DATA-1:0]     i_imm,
  input  logic [NB_REG-1:0]      i_rt,
  input  logic [NB_REG-1:0]      i_rd,
  input  logic                   i_reg_dst,
  input  logic                   i_alu_src,
  input  logic [NB_ALUCTL-1:0]   i_alu_ctl,
  input  logic [NB_MDOP-1:0]     i_md_op,
  input  logic [1:0]             i_fwd_a,
  input  logic [1:0]             i_fwd_b,
  input  logic [NB_DATA-1:0]     i_exmem_result,
  input  logic [NB_DATA-1:0]     i_memwb_result,
  input  logic [NB_CTRL_WBM-1:0] i_ctrl_wbm,
  output logic [NB_ADDR-1:0]     o_branch_pc,
  output logic [NB_DATA-1:0]     o_result,
  output logic                   o_zero,
  output logic [NB_DATA-1:0]     o_store_data,
  output logic [NB_REG-1:0]      o_write_reg,
  output logic [NB_CTRL_WBM-1:0] o_ctrl_wbm,
  output logic                   o_stall,
  output logic                   o_md_busy
);

  logic [NB_DATA-1:0] op_a, fwd_b, alu_b, alu_res, hi, lo;
  logic               alu_zero, live, md_start, mt_hi, mt_lo;

  logic [NB_ADDR-1:0]     branch_pc_q, branch_pc_d;
  logic [NB_DATA-1:0]     result_q, result_d, store_q, store_d;
  logic                   zero_q, zero_d;
  logic [NB_REG-1:0]      write_reg_q, write_reg_d;
  logic [NB_CTRL_WBM-1:0] ctrl_q, ctrl_d;

  always_comb begin
    case (i_fwd_a)
      FWD_EXMEM: op_a = i_exmem_result;
      FWD_MEMWB: op_a = i_memwb_result;
      default:   op_a = i_read_data_1;
    endcase
    case (i_fwd_b)
      FWD_EXMEM: fwd_b = i_exmem_result;
      FWD_MEMWB: fwd_b = i_memwb_result;
      default:   fwd_b = i_read_data_2;
    endcase
  end

  assign alu_b = i_alu_src ? i_imm : fwd_b;

  seg_execute_alu #(
    .NB_DATA   (NB_DATA),
    .NB_ALUCTL (NB_ALUCTL)
  ) u_alu (
    .a_i      (op_a),
    .b_i      (alu_b),
    .ctl_i    (i_alu_ctl),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  // Only HI/LO users wait on the mul/div unit; everything else keeps flowing.
  assign o_stall  = o_md_busy & i_valid & md_is_any(i_md_op);
  assign live     = i_valid & ~i_flush & ~o_stall;
  assign md_start = live & ~o_md_busy & md_is_start(i_md_op);
  assign mt_hi    = live & (i_md_op == MD_MTHI);
  assign mt_lo    = live & (i_md_op == MD_MTLO);

  seg_execute_muldiv #(
    .NB_DATA (NB_DATA),
    .NB_MDOP (NB_MDOP)
  ) u_muldiv (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .start_i (md_start),
    .op_i    (i_md_op),
    .a_i     (op_a),
    .b_i     (fwd_b),
    .mthi_i  (mt_hi),
    .mtlo_i  (mt_lo),
    .hi_o    (hi),
    .lo_o    (lo),
    .busy_o  (o_md_busy)
  );

  always_comb begin
    branch_pc_d = i_PC + (NB_ADDR'(i_imm) << 2);
    case (i_md_op)
      MD_MFHI: result_d = hi;
      MD_MFLO: result_d = lo;
      default: result_d = alu_res;
    endcase
    zero_d      = alu_zero;
    store_d     = fwd_b;
    write_reg_d = i_reg_dst ? i_rd : i_rt;
    ctrl_d      = live ? i_ctrl_wbm : '0;
  end

  // EX/MEM latch; a squashed or stalled slot becomes a bubble via ctrl = 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      branch_pc_q <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      store_q     <= '0;
      write_reg_q <= '0;
      ctrl_q      <= '0;
    end else begin
      branch_pc_q <= branch_pc_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      store_q     <= store_d;
      write_reg_q <= write_reg_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign o_branch_pc  = branch_pc_q;
  assign o_result     = result_q;
  assign o_zero       = zero_q;
  assign o_store_data = store_q;
  assign o_write_reg  = write_reg_q;
  assign o_ctrl_wbm   = ctrl_q;

endmodule

// File: tb/tb_seg_execute_md.sv
module tb_seg_execute_md;
  import mips_ex_pkg::*;

  logic        i_clk, i_rst, i_valid, i_flush;
  logic [31:0] i_PC, i_read_data_1, i_read_data_2, i_imm;
  logic [4:0]  i_rt, i_rd;
  logic        i_reg_dst, i_alu_src;
  logic [3:0]  i_alu_ctl, i_md_op;
  logic [1:0]  i_fwd_a, i_fwd_b;
  logic [31:0] i_exmem_result, i_memwb_result;
  logic [4:0]  i_ctrl_wbm;
  logic [31:0] o_branch_pc, o_result, o_store_data;
  logic        o_zero, o_stall, o_md_busy;
  logic [4:0]  o_write_reg, o_ctrl_wbm;

  seg_execute_md dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_PC(i_PC), .i_read_data_1(i_read_data_1), .i_read_data_2(i_read_data_2),
    .i_imm(i_imm), .i_rt(i_rt), .i_rd(i_rd), .i_reg_dst(i_reg_dst),
    .i_alu_src(i_alu_src), .i_alu_ctl(i_alu_ctl), .i_md_op(i_md_op),
    .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b), .i_exmem_result(i_exmem_result),
    .i_memwb_result(i_memwb_result), .i_ctrl_wbm(i_ctrl_wbm),
    .o_branch_pc(o_branch_pc), .o_result(o_result), .o_zero(o_zero),
    .o_store_data(o_store_data), .o_write_reg(o_write_reg),
    .o_ctrl_wbm(o_ctrl_wbm), .o_stall(o_stall), .o_md_busy(o_md_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;
  int seen_busy = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  int          m_busy_cnt = 0;
  logic [31:0] exp_br, exp_result, exp_store;
  logic        exp_zero, exp_stall, exp_busy, exp_live;
  logic [4:0]  exp_wr, exp_ctrl;

  logic [3:0] alu_codes [8] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR,
                                ALU_SUB, ALU_SLT, ALU_SLTU, ALU_NOR};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd_sel(input logic [1:0] s, input logic [31:0] r);
    if (s == 2'd1) return i_exmem_result;
    if (s == 2'd2) return i_memwb_result;
    return r;
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (c)
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_ADD:  return a + b;
      ALU_XOR:  return a ^ b;
      ALU_SUB:  return a - b;
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_NOR:  return ~(a | b);
      default:  return 32'd0;
    endcase
  endfunction

  task automatic md_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
    int sa, sb, q, r;
    longint p;
    logic [63:0] pu;
    sa = a; sb = b;
    hi = 0; lo = 0;
    if (op == MD_MULT) begin
      p = longint'(sa) * longint'(sb);
      pu = p;
      hi = pu[63:32]; lo = pu[31:0];
    end else if (op == MD_MULTU) begin
      pu = {32'd0, a} * {32'd0, b};
      hi = pu[63:32]; lo = pu[31:0];
    end else if (b == 32'd0) begin
      lo = 32'hFFFFFFFF; hi = a;
    end else if (op == MD_DIV) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        lo = 32'h80000000; hi = 32'd0;
      end else begin
        q = sa / sb; r = sa % sb;
        lo = q; hi = r;
      end
    end else begin
      lo = a / b; hi = a % b;
    end
  endtask

  // Predicts the combinational stall now and everything the coming edge produces.
  task automatic model_eval();
    logic [31:0] a, fb, bb, alu;
    logic busy_pre, live;
    busy_pre  = (m_busy_cnt > 0);
    exp_stall = busy_pre && i_valid && (i_md_op >= 4'd1) && (i_md_op <= 4'd8);
    if (!i_rst) begin
      exp_br = 0; exp_result = 0; exp_zero = 0; exp_store = 0; exp_wr = 0; exp_ctrl = 0;
      m_hi = 0; m_lo = 0; m_busy_cnt = 0; exp_live = 1'b1;
    end else begin
      a   = fwd_sel(i_fwd_a, i_read_data_1);
      fb  = fwd_sel(i_fwd_b, i_read_data_2);
      bb  = i_alu_src ? i_imm : fb;
      alu = alu_model(i_alu_ctl, a, bb);
      live = i_valid && !i_flush && !exp_stall;
      exp_live   = live;
      exp_ctrl   = live ? i_ctrl_wbm : 5'd0;
      exp_result = (i_md_op == MD_MFHI) ? m_hi : (i_md_op == MD_MFLO) ? m_lo : alu;
      exp_zero   = (alu == 32'd0);
      exp_store  = fb;
      exp_wr     = i_reg_dst ? i_rd : i_rt;
      exp_br     = i_PC + (i_imm << 2);
      if (busy_pre) begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
      end else if (live && i_md_op >= 4'd1 && i_md_op <= 4'd4) begin
        md_model(i_md_op, a, fb, m_pend_hi, m_pend_lo);
        m_busy_cnt = 32;
      end else if (live && i_md_op == MD_MTHI) begin
        m_hi = a;
      end else if (live && i_md_op == MD_MTLO) begin
        m_lo = a;
      end
    end
    exp_busy = (m_busy_cnt > 0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return 4'd0;
    if (r < 68) return 4'($urandom_range(1, 4));
    if (r < 80) return 4'($urandom_range(5, 6));
    if (r < 90) return 4'($urandom_range(7, 8));
    return 4'($urandom_range(9, 15));
  endfunction

  task automatic rand_inputs();
    i_rst          = 1'b1;
    i_valid        = ($urandom_range(0, 7) != 0);
    i_flush        = ($urandom_range(0, 15) == 0);
    i_PC           = $urandom;
    i_read_data_1  = pick_val();
    i_read_data_2  = pick_val();
    i_imm          = pick_val();
    i_rt           = 5'($urandom);
    i_rd           = 5'($urandom);
    i_reg_dst      = 1'($urandom);
    i_alu_src      = 1'($urandom);
    i_alu_ctl      = alu_codes[$urandom_range(0, 7)];
    i_md_op        = 4'd0;
    i_fwd_a        = 2'($urandom);
    i_fwd_b        = 2'($urandom);
    i_exmem_result = pick_val();
    i_memwb_result = pick_val();
    i_ctrl_wbm     = 5'($urandom);
  endtask

  task automatic begin_cycle();
    @(negedge i_clk);
    rand_inputs();
  endtask

  task automatic end_cycle();
    #1;
    model_eval();
    if (o_md_busy) seen_busy++;
  endtask

  task automatic start_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    begin_cycle();
    i_valid = 1'b1; i_flush = 1'b0; i_md_op = op;
    i_fwd_a = 2'd0; i_fwd_b = 2'd0;
    i_read_data_1 = a; i_read_data_2 = b;
    end_cycle();
  endtask

  task automatic filler(input int n);
    for (int k = 0; k < n; k++) begin
      begin_cycle();
      i_valid = 1'b1; i_flush = 1'b0;
      end_cycle();
    end
  endtask

  // Issue MFHI/MFLO until it is no longer stalled, then check the read value.
  task automatic read_hilo(input logic [3:0] op, input logic [31:0] expv, input string name);
    for (int k = 0; k < 40; k++) begin
      begin_cycle();
      i_valid = 1'b1; i_flush = 1'b0; i_md_op = op;
      end_cycle();
      if (!exp_stall) break;
    end
    chk({name, "_stall"}, 64'(o_stall), 64'd0);
    @(posedge i_clk); #3;
    chk(name, 64'(o_result), 64'(expv));
  endtask

  // Per-cycle comparison of DUT against the model
  initial begin
    wait (check_en);
    forever begin
      @(posedge i_clk); #2;
      chk("busy", 64'(o_md_busy), 64'(exp_busy));
      chk("ctrl_wbm", 64'(o_ctrl_wbm), 64'(exp_ctrl));
      if (exp_live) begin
        chk("result", 64'(o_result), 64'(exp_result));
        chk("zero", 64'(o_zero), 64'(exp_zero));
        chk("store_data", 64'(o_store_data), 64'(exp_store));
        chk("write_reg", 64'(o_write_reg), 64'(exp_wr));
        chk("branch_pc", 64'(o_branch_pc), 64'(exp_br));
      end
      @(negedge i_clk); #2;
      chk("stall", 64'(o_stall), 64'(exp_stall));
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rand_inputs();
    i_rst = 1'b0; i_valid = 1'b0;
    // Reset
    begin_cycle(); i_rst = 1'b0; i_valid = 1'b0; end_cycle();
    check_en = 1'b1;
    begin_cycle(); i_rst = 1'b0; end_cycle();
    @(posedge i_clk); #3;
    chk("rst_result", 64'(o_result), 64'd0);
    chk("rst_ctrl", 64'(o_ctrl_wbm), 64'd0);
    chk("rst_busy", 64'(o_md_busy), 64'd0);

    // ADD with EX/MEM forwarding on A
    begin_cycle();
    i_valid = 1'b1; i_flush = 1'b0; i_alu_ctl = ALU_ADD; i_alu_src = 1'b0;
    i_fwd_a = 2'd1; i_exmem_result = 32'd5; i_fwd_b = 2'd0; i_read_data_2 = 32'd7;
    i_reg_dst = 1'b1; i_rd = 5'd9; i_rt = 5'd3;
    end_cycle();
    @(posedge i_clk); #3;
    chk("add_result", 64'(o_result), 64'd12);
    chk("add_zero", 64'(o_zero), 64'd0);
    chk("add_write_reg", 64'(o_write_reg), 64'd9);

    // MULT -3 x 7, MFLO issued in busy cycle 5
    start_md(MD_MULT, 32'hFFFFFFFD, 32'd7);
    seen_busy = 0;
    filler(4);
    read_hilo(MD_MFLO, 32'hFFFFFFEB, "mult_lo");
    chk("mult_busy_cycles", 64'(seen_busy), 64'd32);
    read_hilo(MD_MFHI, 32'hFFFFFFFF, "mult_hi");

    // DIVU 100/7 with independent ALU traffic in the background
    start_md(MD_DIVU, 32'd100, 32'd7);
    filler(32);
    read_hilo(MD_MFLO, 32'd14, "divu_lo");
    read_hilo(MD_MFHI, 32'd2, "divu_hi");

    // Signed overflow and divide by zero
    start_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    read_hilo(MD_MFLO, 32'h80000000, "divovf_lo");
    read_hilo(MD_MFHI, 32'd0, "divovf_hi");
    start_md(MD_DIVU, 32'd9, 32'd0);
    read_hilo(MD_MFLO, 32'hFFFFFFFF, "divz_lo");
    read_hilo(MD_MFHI, 32'd9, "divz_hi");
    start_md(MD_DIV, 32'hFFFFFFF9, 32'd2);
    read_hilo(MD_MFLO, 32'hFFFFFFFD, "divs_lo");
    read_hilo(MD_MFHI, 32'hFFFFFFFF, "divs_hi");

    // Flushed MULT must not start
    begin_cycle();
    i_valid = 1'b1; i_flush = 1'b1; i_md_op = MD_MULT; i_fwd_a = 2'd0; i_fwd_b = 2'd0;
    i_read_data_1 = 32'd123; i_read_data_2 = 32'd456;
    end_cycle();
    @(posedge i_clk); #3;
    chk("flush_busy", 64'(o_md_busy), 64'd0);
    chk("flush_ctrl", 64'(o_ctrl_wbm), 64'd0);
    read_hilo(MD_MFHI, 32'hFFFFFFFF, "flush_hi");
    read_hilo(MD_MFLO, 32'hFFFFFFFD, "flush_lo");

    // Reset in busy cycle 10 aborts the operation
    start_md(MD_MULT, 32'd1000, 32'd1000);
    filler(9);
    begin_cycle(); i_rst = 1'b0; i_valid = 1'b1; i_md_op = MD_MFLO; end_cycle();
    @(posedge i_clk); #3;
    chk("rstmid_busy", 64'(o_md_busy), 64'd0);
    chk("rstmid_result", 64'(o_result), 64'd0);
    chk("rstmid_ctrl", 64'(o_ctrl_wbm), 64'd0);
    chk("rstmid_pc", 64'(o_branch_pc), 64'd0);
    read_hilo(MD_MFHI, 32'd0, "rstmid_hi");
    read_hilo(MD_MFLO, 32'd0, "rstmid_lo");

    // MTHI then MFHI
    begin_cycle();
    i_valid = 1'b1; i_flush = 1'b0; i_md_op = MD_MTHI; i_fwd_a = 2'd2; i_memwb_result = 32'hCAFE0001;
    end_cycle();
    read_hilo(MD_MFHI, 32'hCAFE0001, "mthi");

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      begin_cycle();
      i_md_op = pick_op();
      if ($urandom_range(0, 599) == 0) i_rst = 1'b0;
      end_cycle();
    end
    @(posedge i_clk); #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
